// File: rtl/string_assembler_pkg.sv
// Shared constants and state encoding for the display string writer path.
package string_assembler_pkg;

  localparam int         DEFAULT_STRING_LEN = 64;
  localparam logic [7:0] DEFAULT_PAD        = 8'h20;
  localparam logic [7:0] BS_CHAR            = 8'h08;
  localparam logic [7:0] CR_CHAR            = 8'h0D;
  localparam logic [7:0] PRINT_MIN          = 8'h20;
  localparam logic [7:0] PRINT_MAX          = 8'h7E;

  typedef enum logic {
    ACCEPT = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_MIN) && (c <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/string_assembler.sv
// Builds an MSB-first padded string from a char stream; edits land one edge after transfer.
// One char per clock in ACCEPT; char_ready drops while LOCKED (after commit) or in reset.
module string_assembler
  import string_assembler_pkg::*;
#(
  parameter int         STRING_LEN = DEFAULT_STRING_LEN,
  parameter logic [7:0] PAD_CHAR   = DEFAULT_PAD
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [7:0]                        char_data,
  input  logic                              char_valid,
  output logic                              char_ready,
  input  logic                              clear,
  input  logic                              commit,
  output logic [STRING_LEN*8-1:0]           my_string,
  output logic [$clog2(STRING_LEN+1)-1:0]   char_count,
  output logic                              full,
  output logic                              overflow,
  output logic                              string_valid
);

  localparam int                 CW        = $clog2(STRING_LEN+1);
  localparam logic [CW-1:0]      MAX_COUNT = CW'(STRING_LEN);
  localparam logic [CW-1:0]      ONE       = CW'(1);
  localparam logic [STRING_LEN*8-1:0] EMPTY = {STRING_LEN{PAD_CHAR}};

  state_t                  state, state_next;
  logic [STRING_LEN*8-1:0] string_next;
  logic [CW-1:0]           count_next;
  logic                    overflow_next;
  logic                    valid_next;

  assign char_ready = (state == ACCEPT) && !reset;

  always_comb begin
    state_next    = state;
    string_next   = my_string;
    count_next    = char_count;
    overflow_next = overflow;
    valid_next    = 1'b0;

    if (clear) begin
      state_next    = ACCEPT;
      string_next   = EMPTY;
      count_next    = '0;
      overflow_next = 1'b0;
    end else if (state == ACCEPT) begin
      if (commit) begin
        valid_next = 1'b1;
        state_next = LOCKED;
      end else if (char_valid) begin
        if (is_printable(char_data)) begin
          if (char_count != MAX_COUNT) begin
            string_next[8*(STRING_LEN-1-int'(char_count)) +: 8] = char_data;
            count_next = char_count + ONE;
          end else begin
            overflow_next = 1'b1;
          end
        end else if (char_data == BS_CHAR) begin
          // The slot being erased is the last filled one, count-1.
          if (char_count != '0) begin
            string_next[8*(STRING_LEN-int'(char_count)) +: 8] = PAD_CHAR;
            count_next = char_count - ONE;
          end
        end else if (char_data == CR_CHAR) begin
          valid_next = 1'b1;
          state_next = LOCKED;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ACCEPT;
      my_string    <= EMPTY;
      char_count   <= '0;
      full         <= 1'b0;
      overflow     <= 1'b0;
      string_valid <= 1'b0;
    end else begin
      state        <= state_next;
      my_string    <= string_next;
      char_count   <= count_next;
      full         <= (count_next == MAX_COUNT);
      overflow     <= overflow_next;
      string_valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_string_assembler.sv
// Randomized and directed bench for string_assembler against a queue-based string model.
module tb_string_assembler;

  logic         clock;
  logic         reset;
  logic [7:0]   char_data;
  logic         char_valid;
  logic         char_ready;
  logic         clear;
  logic         commit;
  logic [511:0] my_string;
  logic [6:0]   char_count;
  logic         full;
  logic         overflow;
  logic         string_valid;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // Reference model: the string is simply the queue of stored characters.
  byte unsigned q[$];
  bit m_locked = 0;
  bit m_ovf    = 0;
  bit m_sv     = 0;

  string_assembler dut (
    .clock        (clock),
    .reset        (reset),
    .char_data    (char_data),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .clear        (clear),
    .commit       (commit),
    .my_string    (my_string),
    .char_count   (char_count),
    .full         (full),
    .overflow     (overflow),
    .string_valid (string_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [511:0] model_string();
    logic [511:0] s;
    for (int i = 0; i < 64; i++)
      s[511-8*i -: 8] = (i < q.size()) ? q[i] : 8'h20;
    return s;
  endfunction

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clock) begin
    m_sv = 0;
    if (reset) begin
      q.delete();
      m_locked = 0;
      m_ovf = 0;
    end else if (clear) begin
      q.delete();
      m_locked = 0;
      m_ovf = 0;
    end else if (!m_locked) begin
      if (commit) begin
        m_sv = 1;
        m_locked = 1;
      end else if (char_valid) begin
        if (char_data >= 8'h20 && char_data <= 8'h7E) begin
          if (q.size() < 64) q.push_back(char_data);
          else m_ovf = 1;
        end else if (char_data == 8'h08) begin
          if (q.size() > 0) void'(q.pop_back());
        end else if (char_data == 8'h0D) begin
          m_sv = 1;
          m_locked = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("my_string", my_string, model_string());
      check("char_count", 512'(char_count), 512'(q.size()));
      check("full", 512'(full), 512'(q.size() == 64));
      check("overflow", 512'(overflow), 512'(m_ovf));
      check("string_valid", 512'(string_valid), 512'(m_sv));
      check("char_ready", 512'(char_ready), 512'(!m_locked && !reset));
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic cm,
                       input logic cl, input logic rs);
    @(posedge clock);
    #2;
    char_valid = v;
    char_data  = d;
    commit     = cm;
    clear      = cl;
    reset      = rs;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) drive(1'b1, s[i], 1'b0, 1'b0, 1'b0);
  endtask

  logic [511:0] exp_s;

  initial begin
    reset = 1'b1; char_valid = 1'b0; char_data = 8'h00; clear = 1'b0; commit = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    chk_en = 1;
    @(negedge clock); #1;
    check("rst_string", my_string, {64{8'h20}});
    check("rst_count", 512'(char_count), 512'(0));
    check("rst_ready", 512'(char_ready), 512'(1));

    // "PASS" + CR
    feed("PASS");
    drive(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clock); #1;
    exp_s = {32'h50415353, {60{8'h20}}};
    check("pass_string", my_string, exp_s);
    check("pass_count", 512'(char_count), 512'(4));
    check("pass_valid", 512'(string_valid), 512'(1));
    idle();
    @(negedge clock); #1;
    check("pass_valid_once", 512'(string_valid), 512'(0));
    check("pass_locked_ready", 512'(char_ready), 512'(0));

    // Backspace editing
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    feed("AB");
    drive(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    feed("C");
    idle();
    @(negedge clock); #1;
    exp_s = {16'h4143, {62{8'h20}}};
    check("bs_string", my_string, exp_s);
    check("bs_count", 512'(char_count), 512'(2));
    repeat (3) drive(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clock); #1;
    check("bs_floor_count", 512'(char_count), 512'(0));

    // Overflow at 65 characters
    for (int i = 0; i < 65; i++) drive(1'b1, 8'(8'h61 + (i % 26)), 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clock); #1;
    check("ovf_count", 512'(char_count), 512'(64));
    check("ovf_full", 512'(full), 512'(1));
    check("ovf_flag", 512'(overflow), 512'(1));
    check("ovf_last_slot", 512'(my_string[7:0]), 512'(8'h61 + 8'(63 % 26)));
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle();
    @(negedge clock); #1;
    check("clr_string", my_string, {64{8'h20}});
    check("clr_ovf", 512'(overflow), 512'(0));
    check("clr_ready", 512'(char_ready), 512'(1));

    // commit and clear together
    feed("xyz");
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    idle();
    @(negedge clock); #1;
    check("cc_valid", 512'(string_valid), 512'(0));
    check("cc_count", 512'(char_count), 512'(0));
    check("cc_ready", 512'(char_ready), 512'(1));

    // LOCKED ignores chars and further commits
    feed("ok");
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h58, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clock); #1;
    exp_s = {16'h6f6b, {62{8'h20}}};
    check("lock_string", my_string, exp_s);
    check("lock_valid", 512'(string_valid), 512'(0));

    // Reset mid-entry with char_valid high
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    feed("0123456789");
    drive(1'b1, 8'h51, 1'b0, 1'b0, 1'b1);
    @(negedge clock); #1;
    check("rst_mid_ready", 512'(char_ready), 512'(0));
    idle();
    @(negedge clock); #1;
    check("rst_mid_count", 512'(char_count), 512'(0));
    check("rst_mid_string", my_string, {64{8'h20}});

    // Randomized traffic; second half favours long entries to reach full
    for (int n = 0; n < 4000; n++) begin
      logic rs, cl, cm, v;
      logic [7:0] d;
      int k;
      bit longmode;
      longmode = (n >= 2000);
      rs = ($urandom_range(0, 999) < 5);
      cl = ($urandom_range(0, 999) < (longmode ? 8 : 20));
      cm = ($urandom_range(0, 999) < (longmode ? 5 : 30));
      v  = ($urandom_range(0, 99) < 75);
      k  = $urandom_range(0, 99);
      if (k < (longmode ? 92 : 75))      d = 8'($urandom_range(32, 126));
      else if (k < 95)                   d = 8'h08;
      else if (k < 97)                   d = 8'h0D;
      else                               d = 8'($urandom_range(0, 255));
      drive(v, d, cm, cl, rs);
    end
    idle();
    idle();
    @(negedge clock); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
